// File: rtl/reg_wb_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : reg_wb_arbiter_if
// Brief    : ALU / load-return writeback sources and register-file write port.
// Revision : 1.0
// ----------------------------------------------------------------------------
interface reg_wb_arbiter_if #(
    parameter int REG_DATA_WIDTH_POW = 6,
    parameter int REG_MEM_DEPTH_POW  = 5
);
    localparam int c_DATA_W = 1 << REG_DATA_WIDTH_POW;
    localparam int c_DEPTH  = 1 << REG_MEM_DEPTH_POW;

    logic                         alu_valid_in;
    logic [REG_MEM_DEPTH_POW-1:0] alu_rd_in;
    logic [c_DATA_W-1:0]          alu_data_in;
    logic                         alu_ready_out;
    logic                         mem_valid_in;
    logic [REG_MEM_DEPTH_POW-1:0] mem_rd_in;
    logic [c_DATA_W-1:0]          mem_data_in;
    logic [REG_MEM_DEPTH_POW-1:0] rd_out;
    logic [c_DATA_W-1:0]          data_write_out;
    logic                         write_en_out;
    logic [c_DEPTH-1:0]           pending_mask_out;
    logic                         idle_out;

    modport master (
        output alu_valid_in, alu_rd_in, alu_data_in,
        input  alu_ready_out,
        output mem_valid_in, mem_rd_in, mem_data_in,
        input  rd_out, data_write_out, write_en_out, pending_mask_out, idle_out
    );

    modport slave (
        input  alu_valid_in, alu_rd_in, alu_data_in,
        output alu_ready_out,
        input  mem_valid_in, mem_rd_in, mem_data_in,
        output rd_out, data_write_out, write_en_out, pending_mask_out, idle_out
    );
endinterface
`default_nettype wire

// File: rtl/reg_wb_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : reg_wb_arbiter
// Brief    : Merges ALU and load-return writebacks onto one register-file port.
// Revision : 1.0
// ----------------------------------------------------------------------------
module reg_wb_arbiter #(
    parameter int REG_DATA_WIDTH_POW = 6,
    parameter int REG_MEM_DEPTH_POW  = 5,
    parameter int MEM_FIFO_DEPTH     = 2
) (
    input  wire logic         clk_in,
    input  wire logic         rst_in,
    reg_wb_arbiter_if.slave   bus
);
    localparam int c_DATA_W = 1 << REG_DATA_WIDTH_POW;
    localparam int c_DEPTH  = 1 << REG_MEM_DEPTH_POW;
    localparam int c_RD_W   = REG_MEM_DEPTH_POW;
    localparam int c_PTR_W  = $clog2(MEM_FIFO_DEPTH);
    localparam int c_CNT_W  = $clog2(MEM_FIFO_DEPTH + 1);

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_e;

    logic [c_RD_W-1:0]   r_fifo_rd   [MEM_FIFO_DEPTH];
    logic [c_DATA_W-1:0] r_fifo_data [MEM_FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wptr;
    logic [c_PTR_W-1:0]  r_rptr;
    logic [c_CNT_W-1:0]  r_count;
    src_e                r_rr_last;
    logic [c_RD_W-1:0]   r_rd;
    logic [c_DATA_W-1:0] r_data;
    logic                r_we;

    logic                w_enq;
    logic                w_fifo_req;
    logic                w_full;
    logic                w_grant_fifo;
    logic                w_grant_alu;
    logic [c_PTR_W-1:0]  w_wptr_nxt;
    logic [c_PTR_W-1:0]  w_rptr_nxt;
    logic [c_DEPTH-1:0]  w_mask;

    assign w_enq      = bus.mem_valid_in && (bus.mem_rd_in != '0) && !rst_in;
    assign w_fifo_req = (r_count != '0);
    assign w_full     = (r_count == c_CNT_W'(MEM_FIFO_DEPTH));

    // A full FIFO always wins, so a same-cycle load lands in the slot it frees.
    assign w_grant_fifo = w_fifo_req &&
                          (!bus.alu_valid_in || w_full || (r_rr_last == SRC_ALU));
    assign w_grant_alu  = bus.alu_valid_in && !w_grant_fifo;

    assign w_wptr_nxt = (r_wptr == c_PTR_W'(MEM_FIFO_DEPTH - 1)) ? '0 : r_wptr + 1'b1;
    assign w_rptr_nxt = (r_rptr == c_PTR_W'(MEM_FIFO_DEPTH - 1)) ? '0 : r_rptr + 1'b1;

    always_ff @(posedge clk_in) begin
        if (w_enq) begin
            r_fifo_rd[r_wptr]   <= bus.mem_rd_in;
            r_fifo_data[r_wptr] <= bus.mem_data_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_rr_last <= SRC_ALU;
            r_rd      <= '0;
            r_data    <= '0;
            r_we      <= 1'b0;
        end else begin
            if (w_enq) begin
                r_wptr <= w_wptr_nxt;
            end
            if (w_grant_fifo) begin
                r_rptr <= w_rptr_nxt;
            end
            case ({w_enq, w_grant_fifo})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            if (w_grant_fifo) begin
                r_rd      <= r_fifo_rd[r_rptr];
                r_data    <= r_fifo_data[r_rptr];
                r_we      <= (r_fifo_rd[r_rptr] != '0);
                r_rr_last <= SRC_MEM;
            end else if (w_grant_alu) begin
                r_rd      <= bus.alu_rd_in;
                r_data    <= bus.alu_data_in;
                r_we      <= (bus.alu_rd_in != '0);
                r_rr_last <= SRC_ALU;
            end else begin
                r_we      <= 1'b0;
            end
        end
    end

    // Occupied slots are the r_count entries starting at the read pointer.
    always_comb begin
        w_mask = '0;
        for (int k = 0; k < MEM_FIFO_DEPTH; k++) begin
            int idx;
            idx = int'(r_rptr) + k;
            if (idx >= MEM_FIFO_DEPTH) begin
                idx = idx - MEM_FIFO_DEPTH;
            end
            if (c_CNT_W'(k) < r_count) begin
                w_mask[r_fifo_rd[c_PTR_W'(idx)]] = 1'b1;
            end
        end
        if (r_we) begin
            w_mask[r_rd] = 1'b1;
        end
        w_mask[0] = 1'b0;
        if (rst_in) begin
            w_mask = '0;
        end
    end

    assign bus.alu_ready_out    = w_grant_alu && !rst_in;
    assign bus.rd_out           = r_rd;
    assign bus.data_write_out   = r_data;
    assign bus.write_en_out     = r_we;
    assign bus.pending_mask_out = w_mask;
    assign bus.idle_out         = ((r_count == '0) && !r_we) || rst_in;
endmodule
`default_nettype wire
